// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 16-bit ALU between two requesters.
// One operation in flight: accept in IDLE, compute in EXEC, hold the result in RESP.
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_func,
  input  logic [15:0] req0_src1,
  input  logic [15:0] req0_src2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_func,
  input  logic [15:0] req1_src1,
  input  logic [15:0] req1_src2,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_result,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_result,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [1:0] FuncAdd = 2'b00;
  localparam logic [1:0] FuncSub = 2'b01;
  localparam logic [1:0] FuncMul = 2'b10;
  localparam logic [1:0] FuncSlt = 2'b11;

  state_e      state_q, state_d;
  logic        ptr_q;
  logic        owner_q;
  logic [1:0]  func_q;
  logic [15:0] src1_q, src2_q;
  logic [15:0] result_q;

  logic        grant;
  logic        take;
  logic        rsp_ack;
  logic [15:0] alu_result;

  // With both requesters valid the pointer decides; otherwise the lone valid one wins.
  assign grant = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign take  = (state_q == StIdle) && (req0_valid || req1_valid);

  assign req0_ready = take && !grant;
  assign req1_ready = take && grant;

  assign rsp_ack = owner_q ? rsp1_ready : rsp0_ready;

  // Shared ALU; the multiply is evaluated in a 16-bit context so only the low half survives.
  always_comb begin
    alu_result = 16'h0000;
    case (func_q)
      FuncAdd: alu_result = src1_q + src2_q;
      FuncSub: alu_result = src1_q - src2_q;
      FuncMul: alu_result = src1_q * src2_q;
      FuncSlt: alu_result = {15'h0000, (src1_q < src2_q)};
      default: alu_result = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (take) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (rsp_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= RR_INIT;
      owner_q  <= RR_INIT;
      func_q   <= 2'b00;
      src1_q   <= 16'h0000;
      src2_q   <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= grant;
        ptr_q   <= ~grant;
        func_q  <= grant ? req1_func : req0_func;
        src1_q  <= grant ? req1_src1 : req0_src1;
        src2_q  <= grant ? req1_src2 : req0_src2;
      end
      if (state_q == StExec) result_q <= alu_result;
    end
  end

  assign busy        = (state_q != StIdle);
  assign owner       = owner_q;
  assign rsp0_valid  = (state_q == StResp) && !owner_q;
  assign rsp1_valid  = (state_q == StResp) && owner_q;
  assign rsp0_result = rsp0_valid ? result_q : 16'h0000;
  assign rsp1_result = rsp1_valid ? result_q : 16'h0000;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; inputs change 1ns after rising edges.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_func;
  logic [15:0] req0_src1, req0_src2;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_func;
  logic [15:0] req1_src1, req1_src2;
  logic        rsp0_valid, rsp0_ready;
  logic [15:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready;
  logic [15:0] rsp1_result;
  logic        busy, owner;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, wait for its response and take it.
  task automatic run_op(input logic who, input logic [1:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp, input string tag);
    int n;
    if (who) begin
      req1_valid = 1'b1; req1_func = f; req1_src1 = a; req1_src2 = b;
    end else begin
      req0_valid = 1'b1; req0_func = f; req0_src1 = a; req0_src2 = b;
    end
    #1;
    n = 0;
    while (!(who ? req1_ready : req0_ready) && n < 10) begin step(); n++; end
    chk({tag, " accept"}, 32'(who ? req1_ready : req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!(who ? rsp1_valid : rsp0_valid) && n < 10) begin step(); n++; end
    chk({tag, " result"}, 32'(who ? rsp1_result : rsp0_result), 32'(exp));
    if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  int acc_k[$];
  int acc_who[$];

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_func = 2'b00; req0_src1 = 16'h0; req0_src2 = 16'h0;
    req1_valid = 1'b0; req1_func = 2'b00; req1_src1 = 16'h0; req1_src2 = 16'h0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("reset rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("reset rsp0_result", 32'(rsp0_result), 32'd0);
    chk("reset owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single ADD with cycle-exact latency
    req0_valid = 1'b1; req0_func = 2'b00; req0_src1 = 16'h1234; req0_src2 = 16'h0001;
    #1;
    chk("add req0_ready T", 32'(req0_ready), 32'd1);
    chk("add req1_ready T", 32'(req1_ready), 32'd0);
    chk("add busy T", 32'(busy), 32'd0);
    step();
    req0_valid = 1'b0;
    chk("add busy T+1", 32'(busy), 32'd1);
    chk("add rsp0_valid T+1", 32'(rsp0_valid), 32'd0);
    step();
    chk("add rsp0_valid T+2", 32'(rsp0_valid), 32'd1);
    chk("add rsp0_result", 32'(rsp0_result), 32'h1235);
    chk("add rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("add busy T+2", 32'(busy), 32'd1);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    chk("add busy after", 32'(busy), 32'd0);
    chk("add rsp0_valid after", 32'(rsp0_valid), 32'd0);

    // Wrap and width rules from requester 1
    run_op(1'b1, 2'b01, 16'h0000, 16'h0001, 16'hFFFF, "sub wrap");
    run_op(1'b1, 2'b10, 16'h0100, 16'h0100, 16'h0000, "mul overflow");
    run_op(1'b1, 2'b10, 16'h00FF, 16'h0003, 16'h02FD, "mul small");
    run_op(1'b1, 2'b11, 16'h0001, 16'hFFFF, 16'h0001, "slt lt");
    run_op(1'b1, 2'b11, 16'hFFFF, 16'h0001, 16'h0000, "slt ge");

    // Fairness from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    req0_valid = 1'b1; req0_func = 2'b00; req0_src1 = 16'h0001; req0_src2 = 16'h0001;
    req1_valid = 1'b1; req1_func = 2'b00; req1_src1 = 16'h0002; req1_src2 = 16'h0002;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (req0_ready || req1_ready) begin
        acc_k.push_back(k);
        acc_who.push_back(req1_ready ? 1 : 0);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk("fair count", 32'(acc_k.size()), 32'd4);
    for (int i = 0; i < acc_k.size() && i < 4; i++) begin
      chk($sformatf("fair grant %0d", i), 32'(acc_who[i]), 32'(i % 2));
      chk($sformatf("fair cycle %0d", i), 32'(acc_k[i]), 32'(3 * i));
    end
    #1;

    // Backpressure on requester 1 while requester 0 waits
    req1_valid = 1'b1; req1_func = 2'b00; req1_src1 = 16'd5; req1_src2 = 16'd7;
    #1;
    chk("bp req1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_func = 2'b00; req0_src1 = 16'h00AA; req0_src2 = 16'h0011;
    #1;
    chk("bp req0_ready exec", 32'(req0_ready), 32'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp rsp1_valid %0d", c), 32'(rsp1_valid), 32'd1);
      chk($sformatf("bp rsp1_result %0d", c), 32'(rsp1_result), 32'h000C);
      chk($sformatf("bp req0_ready %0d", c), 32'(req0_ready), 32'd0);
      chk($sformatf("bp busy %0d", c), 32'(busy), 32'd1);
      step();
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp req0_ready handshake", 32'(req0_ready), 32'd0);
    step();
    rsp1_ready = 1'b0;
    chk("bp req0_ready next", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    chk("bp req0 exec busy", 32'(busy), 32'd1);

    // Reset during EXEC of the req0 op
    rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst rsp0_result", 32'(rsp0_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst no stale rsp0", 32'(rsp0_valid), 32'd0);
    req0_valid = 1'b1; req0_func = 2'b01; req0_src1 = 16'h0010; req0_src2 = 16'h0003;
    req1_valid = 1'b1; req1_func = 2'b00; req1_src1 = 16'h0001; req1_src2 = 16'h0001;
    #1;
    chk("rst req0 first", 32'(req0_ready), 32'd1);
    chk("rst req1 waits", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("rst rsp0_result", 32'(rsp0_result), 32'h000D);
    chk("rst rsp1_valid", 32'(rsp1_valid), 32'd0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;

    // Withdrawn req0 pulse during req1 RESP leaves the pointer alone
    req1_valid = 1'b1; req1_func = 2'b10; req1_src1 = 16'h0003; req1_src2 = 16'h0004;
    #1;
    chk("wd req1 accept", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b1;
    #1;
    chk("wd req0_ready pulse", 32'(req0_ready), 32'd0);
    chk("wd rsp1_result", 32'(rsp1_result), 32'h000C);
    step();
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("wd grant by ptr req0", 32'(req0_ready), 32'd1);
    chk("wd grant by ptr req1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("wd owner", 32'(owner), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit ALU between two independent requesters (for example the execute stage and an address/loop-counter unit). Arbitrates round-robin, sequences each operation through a three-state FSM, and returns the registered result to the winning requester over a valid/ready response channel. Exactly one operation is in flight at a time. The shared ALU is instantiated inside this block.

## Interface
Parameters:
- RR_INIT, 1'b0, requester index holding priority after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_func  in  2  00 ADD, 01 SUB, 10 MUL (low 16 bits), 11 SLT (unsigned).
- req0_src1, req0_src2  in  16  operands.
- req1_valid, req1_ready, req1_func, req1_src1, req1_src2: same as requester 0.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes result.
- rsp0_result  out  16  result for requester 0.
- rsp1_valid, rsp1_ready, rsp1_result: same as requester 0.
- busy  out  1  FSM not in IDLE.
- owner  out  1  index of the current or last granted requester.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE, grant selection:
  - Neither valid: stay in IDLE.
  - Only one valid: that requester wins.
  - Both valid: the requester indexed by priority pointer `ptr` wins.
- IDLE, acceptance: `reqN_ready` = (state==IDLE) && grant==N, combinational from state and valids. On acceptance:
  - Latch func, src1, src2 into op registers.
  - owner <= N; ptr <= ~N (the just-granted requester drops to lowest priority).
  - Go to EXEC.
- EXEC: drive ALU from op registers; result_q <= ALU output; go to RESP. Always one cycle.
- RESP:
  - rsp[owner]_valid = 1 and rsp[owner]_result = result_q. The other response port keeps valid 0.
  - On rsp[owner]_ready=1, go to IDLE. No new request is accepted in this cycle.
  - Wait indefinitely while ready is low. result_q and valid stay stable.
- Arithmetic, all unsigned modulo 2^16:
  - ADD and SUB wrap.
  - MUL keeps the low 16 bits of the 32-bit product.
  - SLT returns 16'h0001 if src1<src2, else 16'h0000.
- Requester rules: hold func and operands stable while valid=1 and ready=0. Deasserting valid before acceptance is legal and has no effect.
- Response data is undefined-free: the rspN_result of the non-owner port, and of the owner outside RESP, drives 16'h0000.

## Timing
- Reset values:
  - Asynchronous reset: state=IDLE, ptr=RR_INIT, owner=RR_INIT, result_q=0, op registers=0.
  - Outputs: rsp0/1_valid=0, rsp0/1_result=0, busy=0.
  - reqN_ready follows the IDLE rule. Requesters keep valid low during reset.
- Latency: accepted at edge T (ready=1 in cycle T), EXEC in cycle T+1, rsp_valid high from cycle T+2.
- Throughput: at best one operation per 3 cycles (accept, exec, respond with ready=1). The next acceptance is possible in the cycle after the response handshake.
- Simultaneous events: both valid in IDLE resolves by ptr only. A requester's valid arriving while busy waits. Rsp ready asserted outside RESP is ignored.
- Reset mid-EXEC or mid-RESP: the transaction is abandoned with no response delivered. Outputs return to reset values asynchronously.
- busy=1 in EXEC and RESP only.

## Test plan
- Single ADD: req0 valid, func 00, 16'h1234+16'h0001. Response: req0_ready in cycle T, rsp0_valid in T+2 with 16'h1235, busy high in T+1..T+2, rsp1_valid stays 0.
- Wrap and width rules, issued from req1:
  - SUB 16'h0000-16'h0001 -> 16'hFFFF.
  - MUL 16'h0100*16'h0100 -> 16'h0000.
  - MUL 16'h00FF*16'h0003 -> 16'h02FD.
  - SLT 16'h0001,16'hFFFF -> 16'h0001.
  - SLT 16'hFFFF,16'h0001 -> 16'h0000.
- Fairness: both requesters held valid continuously with rsp ready=1. Response: grants go 0,1,0,1 after reset (RR_INIT=0), with acceptances exactly 3 cycles apart.
- Backpressure: req1 op ADD 5+7, rsp1_ready low for 5 cycles while req0 valid. Response: rsp1_valid=1 with 16'h000C held stable, req0_ready=0 throughout, busy=1. After ready rises, req0 is accepted in the following cycle.
- Reset mid-operation: assert rst_n=0 during EXEC of a req0 op. Response:
  - Immediately: busy=0, rsp0_valid=0, result=0.
  - After release, with both valid: req0 (RR_INIT) granted first, no stale response.
- Valid withdrawal: req0 valid pulses for one cycle while RESP is pending for req1. Response: no acceptance, ptr unchanged, next grant goes by ptr.
